// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern source: pixel widths,
// pattern and state encodings, and the colour-bar palette.
package vga_pkg;

  localparam int COLOR_W = 10;
  localparam int PIXEL_W = 3 * COLOR_W;

  // Pattern selector encoding, matches the pattern_sel input.
  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_RAMP  = 2'd3
  } pat_e;

  // Frame streaming FSM states.
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam logic [PIXEL_W-1:0] PIX_WHITE = 30'h3FFF_FFFF;
  localparam logic [PIXEL_W-1:0] PIX_BLACK = 30'h0000_0000;

  // Colour bars left to right, {R,G,B}.
  localparam logic [PIXEL_W-1:0] BAR_TABLE [8] = '{
    30'h3FFF_FFFF,  // white
    30'h3FFF_FC00,  // yellow
    30'h000F_FFFF,  // cyan
    30'h000F_FC00,  // green
    30'h3FF0_03FF,  // magenta
    30'h3FF0_0000,  // red
    30'h0000_03FF,  // blue
    30'h0000_0000   // black
  };

endpackage

// File: rtl/vga_pattern_rom.sv
// Combinational pixel generator: maps the current raster position and
// latched pattern settings to one 30-bit {R,G,B} pixel.
module vga_pattern_rom
  import vga_pkg::*;
#(
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int CHECK_LOG2 = 5
) (
  input  pat_e               pat_i,
  input  logic [XW-1:0]      x_i,
  input  logic [YW-1:0]      y_i,
  input  logic [2:0]         bar_idx_i,
  input  logic [PIXEL_W-1:0] rgb_i,
  output logic [PIXEL_W-1:0] pixel_o
);

  logic [COLOR_W-1:0] ramp;
  logic               chk_odd;

  // Ramp is the column index truncated (or zero-extended) to one channel.
  assign ramp = COLOR_W'(x_i);

  // Square parity; widening to 32 bits keeps the bit select legal even
  // when the square size exceeds the raster dimensions.
  assign chk_odd = (((32'(x_i) >> CHECK_LOG2) ^ (32'(y_i) >> CHECK_LOG2)) & 32'd1) != 32'd0;

  // Select the pixel colour for the active pattern.
  always_comb begin
    pixel_o = PIX_BLACK;
    case (pat_i)
      PAT_BARS:  pixel_o = BAR_TABLE[bar_idx_i];
      PAT_CHECK: pixel_o = chk_odd ? PIX_BLACK : PIX_WHITE;
      PAT_SOLID: pixel_o = rgb_i;
      PAT_RAMP:  pixel_o = {ramp, ramp, ramp};
      default:   pixel_o = PIX_BLACK;
    endcase
  end

endmodule

// File: rtl/vga_pattern_source.sv
// Avalon-ST test-pattern source: emits whole frames in raster order, one
// packet per frame, with ready-latency-0 backpressure.
//
// Handshake: a beat transfers on a clock edge where stream_valid and
// stream_ready are both high. stream_valid never depends on stream_ready,
// and data/SOP/EOP are functions of registered state only, so they hold
// steady through any stall.
module vga_pattern_source
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        clock_clk,
  input  logic        rest_reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [29:0] solid_rgb,
  output logic [29:0] stream_data,
  output logic        stream_startofpacket,
  output logic        stream_endofpacket,
  output logic        stream_valid,
  input  logic        stream_ready,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  state_e             state_q;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [BCW-1:0]     bar_cnt_q, bar_cnt_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  pat_e               pat_q;
  logic [PIXEL_W-1:0] rgb_q;
  logic [15:0]        frame_count_q;

  logic               at_eol;
  logic               at_eof;
  logic [PIXEL_W-1:0] pixel;

  assign at_eol = (x_q == XW'(H_ACTIVE - 1));
  assign at_eof = at_eol && (y_q == YW'(V_ACTIVE - 1));

  // Bar position one pixel to the right; a bar boundary rolls the counter
  // into the next palette entry, so no divider is needed.
  always_comb begin
    bar_cnt_d = bar_cnt_q + BCW'(1);
    bar_idx_d = bar_idx_q;
    if (bar_cnt_q == BCW'(BAR_W - 1)) begin
      bar_cnt_d = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end
  end

  // Frame FSM with raster counters; everything moves only on a transfer.
  always_ff @(posedge clock_clk or posedge rest_reset) begin
    if (rest_reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      pat_q         <= PAT_BARS;
      rgb_q         <= '0;
      frame_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q   <= STREAM;
            pat_q     <= pat_e'(pattern_sel);
            rgb_q     <= solid_rgb;
            x_q       <= '0;
            y_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
          end
        end
        STREAM: begin
          if (stream_ready) begin
            if (at_eof) begin
              frame_count_q <= frame_count_q + 16'd1;
              x_q           <= '0;
              y_q           <= '0;
              bar_cnt_q     <= '0;
              bar_idx_q     <= '0;
              // Settings only change here, so a frame is never mixed.
              if (enable) begin
                pat_q <= pat_e'(pattern_sel);
                rgb_q <= solid_rgb;
              end else begin
                state_q <= IDLE;
              end
            end else if (at_eol) begin
              x_q       <= '0;
              y_q       <= y_q + YW'(1);
              bar_cnt_q <= '0;
              bar_idx_q <= '0;
            end else begin
              x_q       <= x_q + XW'(1);
              bar_cnt_q <= bar_cnt_d;
              bar_idx_q <= bar_idx_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  vga_pattern_rom #(
    .XW        (XW),
    .YW        (YW),
    .CHECK_LOG2(CHECK_LOG2)
  ) u_rom (
    .pat_i    (pat_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .bar_idx_i(bar_idx_q),
    .rgb_i    (rgb_q),
    .pixel_o  (pixel)
  );

  // Outputs are qualified by the state so an idle source shows all zeros.
  assign stream_valid         = (state_q == STREAM);
  assign busy                 = (state_q == STREAM);
  assign stream_startofpacket = stream_valid && (x_q == '0) && (y_q == '0);
  assign stream_endofpacket   = stream_valid && at_eof;
  assign stream_data          = stream_valid ? pixel : '0;
  assign frame_count          = frame_count_q;

endmodule

// File: tb/tb_vga_pattern_source.sv
// Directed bench for vga_pattern_source: small 8x4 raster for protocol and
// pattern checks, plus a 64x64 instance for the checkerboard.
module tb_vga_pattern_source;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [29:0] solid_rgb;
  logic [29:0] data;
  logic        sop, eop, valid, ready, busy;
  logic [15:0] fc;

  logic        b_enable, b_ready;
  logic [1:0]  b_pat;
  logic [29:0] b_rgb;
  logic [29:0] b_data;
  logic        b_sop, b_eop, b_valid, b_busy;
  logic [15:0] b_fc;

  vga_pattern_source #(.H_ACTIVE(8), .V_ACTIVE(4), .CHECK_LOG2(5)) dut_a (
    .clock_clk(clk), .rest_reset(rst), .enable(enable),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .stream_data(data), .stream_startofpacket(sop),
    .stream_endofpacket(eop), .stream_valid(valid),
    .stream_ready(ready), .busy(busy), .frame_count(fc)
  );

  vga_pattern_source #(.H_ACTIVE(64), .V_ACTIVE(64), .CHECK_LOG2(5)) dut_b (
    .clock_clk(clk), .rest_reset(rst), .enable(b_enable),
    .pattern_sel(b_pat), .solid_rgb(b_rgb),
    .stream_data(b_data), .stream_startofpacket(b_sop),
    .stream_endofpacket(b_eop), .stream_valid(b_valid),
    .stream_ready(b_ready), .busy(b_busy), .frame_count(b_fc)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [29:0] exp_q[$];
  logic [29:0] got_d[$];
  logic        got_s[$];
  logic        got_e[$];

  logic [29:0] bar_tab [8] = '{
    30'h3FFFFFFF, 30'h3FFFFC00, 30'h000FFFFF, 30'h000FFC00,
    30'h3FF003FF, 30'h3FF00000, 30'h000003FF, 30'h00000000
  };

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected pixel for beat i of an 8x4 frame (kind: 0 bars, 2 solid, 3 ramp).
  function automatic logic [29:0] exp_pix(input int kind, input int i, input logic [29:0] rgb);
    logic [29:0] x;
    x = 30'(i % 8);
    case (kind)
      0:       exp_pix = bar_tab[i % 8];
      2:       exp_pix = rgb;
      default: exp_pix = (x << 20) | (x << 10) | x;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Runs at "phase" = 1 time unit after a rising edge. mode 0: ready held
  // high; mode 1: ready toggles plus one 5-cycle stall mid-line.
  task automatic run_frame(input int mode, input int nbeats, input int en_drop_at,
                           input int chg_at);
    int cnt = 0;
    int cyc = 0;
    int stall_at;
    int stall_left = 0;
    logic stall_done = 1'b0;
    logic prev_stall = 1'b0;
    logic [29:0] pd = '0;
    logic ps = 1'b0;
    logic pe = 1'b0;
    logic r;
    stall_at = $urandom_range(9, 13);
    got_d.delete(); got_s.delete(); got_e.delete();
    while (cnt < nbeats && cyc < 400) begin
      if (mode == 1 && !stall_done && cnt == stall_at) begin
        stall_left = 5;
        stall_done = 1'b1;
      end
      if (mode == 0) r = 1'b1;
      else if (stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end else r = (cyc % 2 == 0);
      ready = r;
      if (prev_stall) begin
        check_eq("stall_valid", 32'(valid), 32'd1);
        check_eq("stall_data", 32'(data), 32'(pd));
        check_eq("stall_sop", 32'(sop), 32'(ps));
        check_eq("stall_eop", 32'(eop), 32'(pe));
      end
      if (valid && r) begin
        got_d.push_back(data);
        got_s.push_back(sop);
        got_e.push_back(eop);
        if (cnt == en_drop_at) enable = 1'b0;
        if (cnt == chg_at) begin
          pattern_sel = 2'd3;
          solid_rgb   = 30'h0ABCDEF;
        end
        cnt++;
      end
      prev_stall = valid && !r;
      pd = data;
      ps = sop;
      pe = eop;
      @(posedge clk);
      #1;
      cyc++;
    end
    ready = 1'b1;
    check_eq("frame_beats", 32'(cnt), 32'(nbeats));
  endtask

  task automatic check_frame(input string name, input int kind, input logic [29:0] rgb);
    int n;
    n = got_d.size();
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(exp_pix(kind, i, rgb));
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_px%0d", name, i), 32'(got_d[i]), 32'(exp_q.pop_front()));
      check_eq($sformatf("%s_sop%0d", name, i), 32'(got_s[i]), 32'(i == 0));
      check_eq($sformatf("%s_eop%0d", name, i), 32'(got_e[i]), 32'(i == 31));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int beats;
    rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = '0; ready = 1'b0;
    b_enable = 1'b0; b_ready = 1'b1; b_pat = 2'd1; b_rgb = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fc", 32'(fc), 32'd0);
    check_eq("rst_data", 32'(data), 32'd0);
    check_eq("rst_sop", 32'(sop), 32'd0);
    check_eq("rst_eop", 32'(eop), 32'd0);
    check_eq("rst_b_valid", 32'(b_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_hold", 32'(valid), 32'd0);

    // T1: bars, ready always high
    enable = 1'b1;
    ready  = 1'b1;
    check_eq("t1_pre_valid", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t1_first_valid", 32'(valid), 32'd1);
    check_eq("t1_first_sop", 32'(sop), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_first_data", 32'(data), 32'h3FFFFFFF);
    run_frame(0, 32, -1, -1);
    check_frame("t1", 0, '0);
    check_eq("t1_fc", 32'(fc), 32'd1);
    check_eq("t1_nobubble", 32'(valid), 32'd1);
    check_eq("t1_next_sop", 32'(sop), 32'd1);

    // T2: same pattern under backpressure
    run_frame(1, 32, -1, -1);
    check_frame("t2", 0, '0);
    check_eq("t2_fc", 32'(fc), 32'd2);

    // T3: settings change only at frame boundaries
    pattern_sel = 2'd2;
    solid_rgb   = 30'h12345678;
    run_frame(0, 32, -1, -1);
    check_frame("t3a", 0, '0);
    run_frame(0, 32, -1, 10);
    check_frame("t3b", 2, 30'h12345678);
    run_frame(0, 32, -1, -1);
    check_frame("t3c", 3, '0);
    check_eq("t3_fc", 32'(fc), 32'd5);

    // T4: enable dropped mid-frame, frame still completes
    run_frame(0, 32, 5, -1);
    check_frame("t4", 3, '0);
    check_eq("t4_valid_off", 32'(valid), 32'd0);
    check_eq("t4_busy_off", 32'(busy), 32'd0);
    check_eq("t4_fc", 32'(fc), 32'd6);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t4_idle_stays", 32'(valid), 32'd0);
    enable = 1'b1;
    check_eq("t4_pre_valid", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t4_restart_valid", 32'(valid), 32'd1);
    check_eq("t4_restart_sop", 32'(sop), 32'd1);

    // T5: asynchronous reset mid-frame
    run_frame(0, 17, -1, -1);
    check_frame("t5a", 3, '0);
    check_eq("t5_pre_valid", 32'(valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_async_valid", 32'(valid), 32'd0);
    check_eq("t5_async_busy", 32'(busy), 32'd0);
    check_eq("t5_async_fc", 32'(fc), 32'd0);
    check_eq("t5_async_data", 32'(data), 32'd0);
    pattern_sel = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("t5_rel_valid", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t5_restart_valid", 32'(valid), 32'd1);
    check_eq("t5_restart_sop", 32'(sop), 32'd1);
    check_eq("t5_restart_data", 32'(data), 32'h3FFFFFFF);
    run_frame(0, 32, -1, -1);
    check_frame("t5", 0, '0);
    check_eq("t5_fc", 32'(fc), 32'd1);
    enable = 1'b0;

    // T6: checkerboard on a 64x64 raster
    b_enable = 1'b1;
    @(posedge clk);
    #1;
    beats = 0;
    for (int cyc = 0; cyc < 4300 && beats < 4096; cyc++) begin
      if (b_valid) begin
        if (beats == 0) begin
          check_eq("t6_px_0_0", 32'(b_data), 32'h3FFFFFFF);
          check_eq("t6_sop", 32'(b_sop), 32'd1);
        end
        if (beats == 32)   check_eq("t6_px_32_0", 32'(b_data), 32'h0);
        if (beats == 2048) check_eq("t6_px_0_32", 32'(b_data), 32'h0);
        if (beats == 2080) check_eq("t6_px_32_32", 32'(b_data), 32'h3FFFFFFF);
        if (beats == 4095) begin
          check_eq("t6_px_63_63", 32'(b_data), 32'h3FFFFFFF);
          check_eq("t6_eop", 32'(b_eop), 32'd1);
        end
        beats++;
      end
      @(posedge clk);
      #1;
    end
    check_eq("t6_beats", 32'(beats), 32'd4096);
    check_eq("t6_fc", 32'(b_fc), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_pattern_source.md
Name: vga_pattern_source

Overview:
Avalon-ST video pixel source that feeds the VGA controller's 30-bit stream sink, the sync stream input of the display subsystem. It generates whole frames of test-pattern pixels in raster order. Each frame is one packet: SOP on the first pixel, EOP on the last. It honours sink backpressure with ready latency 0. It is used for bring-up and display checks before a framebuffer reader exists.

Parameters:
H_ACTIVE, 640, pixels per line (multiple of 8, ≥8)
V_ACTIVE, 480, lines per frame (≥2)
CHECK_LOG2, 5, checkerboard square size is 2**CHECK_LOG2 pixels

Ports:
clock_clk  in  1  system clock
rest_reset  in  1  asynchronous, active-high reset
enable  in  1  1 = stream frames continuously; 0 = finish current frame then idle
pattern_sel  in  2  0 colour bars, 1 checkerboard, 2 solid, 3 grey ramp
solid_rgb  in  30  colour for pattern 2, {R[29:20],G[19:10],B[9:0]}
stream_data  out  30  pixel {R,G,B}, 10 bits each
stream_startofpacket  out  1  first pixel of frame
stream_endofpacket  out  1  last pixel of frame
stream_valid  out  1  beat valid
stream_ready  in  1  sink accepts beat this cycle
busy  out  1  frame in progress (state STREAM)
frame_count  out  16  completed frames, wraps 0xFFFF→0

Behaviour:
- Reset and clock: one clock (clock_clk). Reset is asynchronous, active-high (rest_reset). It forces state IDLE, x=y=0, bar counters 0, frame_count=0, stream_valid=0, busy=0, SOP=EOP=0, stream_data=0.
- Transfer: a beat is transferred on a clock_clk edge where stream_valid && stream_ready.
- IDLE state: stream_valid=0. When enable=1, latch pattern_sel and solid_rgb into pat_q/rgb_q, clear x and y, and go to STREAM on the next edge. First valid beat appears 1 cycle after enable is sampled high.
- STREAM state: stream_valid=1 on every cycle. Counters advance only on a transfer:
  - x++ each transfer.
  - At x=H_ACTIVE-1: x←0, y++.
- Stall rule: while stream_valid && !stream_ready, stream_data, SOP and EOP must hold stable. Data is a pure function of registered x, y, bar state, pat_q and rgb_q.
- Packet markers:
  - SOP = (x==0 && y==0).
  - EOP = (x==H_ACTIVE-1 && y==V_ACTIVE-1).
- End of frame, on EOP transfer:
  - frame_count++.
  - If enable=1: stay in STREAM, re-latch pattern_sel/solid_rgb, set x=y=0. No bubble: the SOP beat is valid on the next cycle.
  - If enable=0: go to IDLE; stream_valid=0 next cycle.
- Mid-frame changes:
  - enable dropping mid-frame never truncates the frame.
  - pattern_sel and solid_rgb changes take effect only at a frame boundary.
- Colour bars (pattern 0):
  - Bar width BAR_W = H_ACTIVE/8. No divider: bar_cnt counts 0..BAR_W-1 and bar_idx 0..7; both advance with x and clear with x.
  - bar_idx order: white 3FF/3FF/3FF, yellow 3FF/3FF/0, cyan 0/3FF/3FF, green 0/3FF/0, magenta 3FF/0/3FF, red 3FF/0/0, blue 0/0/3FF, black 0/0/0.
- Checkerboard (pattern 1): white when x[CHECK_LOG2]^y[CHECK_LOG2]==0, else black.
- Solid (pattern 2): rgb_q.
- Grey ramp (pattern 3): R=G=B=x[9:0], truncated to 10 bits. It wraps for H_ACTIVE>1024.
- Counter widths: x and y are $clog2 of H_ACTIVE and V_ACTIVE respectively. No wrap is reachable other than the explicit frame-end clear.
- Reset mid-frame: the frame is abandoned and valid drops immediately (asynchronous). After release, the next frame starts with SOP, so the sink resynchronises on SOP.
- busy = (state==STREAM).

Decomposition:
- Shared package vga_pkg:
  - RGB width constants (COLOR_W=10, PIXEL_W=30).
  - pattern enum (PAT_BARS, PAT_CHECK, PAT_SOLID, PAT_RAMP).
  - 8-entry colour-bar constant table.
  - state enum {IDLE, STREAM}.
- Sub-module vga_pattern_rom: purely combinational mapping of (pat, x, y, bar_idx, rgb) to a 30-bit pixel. The top holds the FSM, counters and handshake.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=4, enable=1, ready always 1, pattern 0 → 32 beats. SOP only on beat 0, EOP only on beat 31. Bars are 1 px wide: beat 0=3FFFFFFF, beat 7=0. frame_count=1 after beat 31. Next cycle is SOP with no bubble.
- Same config, ready toggling 1/0 every cycle plus a random 5-cycle stall mid-line → data, SOP and EOP stable during stalls. 32 transfers per frame, pixel order identical to the unstalled run.
- Pattern 2 with solid_rgb=0x12345678 & 0x3FFFFFFF; solid_rgb and pattern_sel changed to 3 at beat 10 → frame 1 all 0x12345678. Frame 2 ramp: beat x has R=G=B=x.
- enable dropped at beat 5 → frame completes through EOP at beat 31. Then valid=0, busy=0, frame_count=1. Re-raise enable → first valid beat 1 cycle later with SOP.
- rest_reset pulsed asynchronously at beat 17 (between edges) → valid=0 immediately, frame_count=0. After release with enable=1, stream restarts at x=y=0 with SOP.
- Pattern 1, H=64, V=64, CHECK_LOG2=5 → pixel (0,0) white, (32,0) black, (32,32) white, (63,63) white.
